// File: rtl/compare_seq.sv
// compare_seq: multi-cycle magnitude comparator, one SLICE-bit slice per
// clock, most-significant slice first. Unsigned or two's-complement compare
// with a start/busy/done handshake. The results use the ALU compare encoding:
// dataOut 00 means A==B, 01 means A>B and 10 means A<B.
//
// Optional feature macro: COMPARE_EARLY_EXIT_EN
//   defined   : the compare ends on the first differing slice
//               (latency 1..NSLICE cycles).
//   undefined : every slice is walked (fixed latency of NSLICE cycles), and
//               the first difference found is held to the end.
// The two builds give the same results; only the latency differs.

module compare_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signedMode,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dataOut,
  output logic             zeroFlag,
  output logic             overflowFlag,
  output logic             carryoutFlag,
  output logic             negativeFlag
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(0);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

`ifdef COMPARE_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  // Unsigned compare of one slice pair, in the dataOut encoding.
  function automatic logic [1:0] slice_cmp(input logic [SLICE-1:0] a,
                                           input logic [SLICE-1:0] b);
    if (a > b) begin
      return RES_GT;
    end else if (a < b) begin
      return RES_LT;
    end else begin
      return RES_EQ;
    end
  endfunction

  logic [0:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic             zero_pend_r;
  logic [IDXW-1:0]  idx_r;
  logic [1:0]       pend_r;
  logic             done_r;
  logic [1:0]       data_out_r;
  logic             zero_flag_r;
  logic             neg_flag_r;

  int unsigned      shift_s;
  logic             bias_s;
  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [1:0]       slice_res_s;
  logic [1:0]       eff_res_s;
  logic             finish_s;

  // Select the current slice, apply the sign bias on the top slice, and
  // decide whether this RUN cycle ends the compare.
  always_comb begin
    shift_s     = 32'(idx_r) * 32'(SLICE);
    // Flipping the sign bit of both top slices maps two's-complement
    // ordering onto unsigned ordering.
    bias_s      = signed_r & (idx_r == TOP_IDX);
    slice_a_s   = SLICE'(a_r >> shift_s) ^ (bias_s ? MSB_MASK : {SLICE{1'b0}});
    slice_b_s   = SLICE'(b_r >> shift_s) ^ (bias_s ? MSB_MASK : {SLICE{1'b0}});
    slice_res_s = slice_cmp(slice_a_s, slice_b_s);
    // A difference already seen in a more significant slice wins.
    eff_res_s   = (pend_r != RES_EQ) ? pend_r : slice_res_s;
    finish_s    = (idx_r == LAST_IDX) | (EARLY_EXIT & (eff_res_s != RES_EQ));
  end

  // Handshake FSM, operand capture, slice walk and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      signed_r    <= 1'b0;
      zero_pend_r <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      pend_r      <= RES_EQ;
      done_r      <= 1'b0;
      data_out_r  <= RES_EQ;
      zero_flag_r <= 1'b0;
      neg_flag_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r         <= busA;
            b_r         <= busB;
            signed_r    <= signedMode;
            zero_pend_r <= (busA == {WIDTH{1'b0}}) && (busB == {WIDTH{1'b0}});
            idx_r       <= TOP_IDX;
            pend_r      <= RES_EQ;
            state_r     <= RUN;
          end else begin
            state_r     <= IDLE;
          end
        end
        RUN: begin
          if (finish_s) begin
            data_out_r  <= eff_res_s;
            neg_flag_r  <= (eff_res_s == RES_LT);
            zero_flag_r <= zero_pend_r;
            done_r      <= 1'b1;
            state_r     <= IDLE;
          end else begin
            idx_r       <= idx_r - IDXW'(1);
            pend_r      <= eff_res_s;
            state_r     <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_r == RUN);
  assign done         = done_r;
  assign dataOut      = data_out_r;
  assign zeroFlag     = zero_flag_r;
  assign negativeFlag = neg_flag_r;
  assign overflowFlag = 1'b0;
  assign carryoutFlag = 1'b0;

endmodule

// File: tb/tb_compare_seq.sv
// Self-checking bench for compare_seq at the default WIDTH=32, SLICE=8.
// It is aware of COMPARE_EARLY_EXIT_EN only through the expected latency.

module tb_compare_seq;

  localparam int W  = 32;
  localparam int SL = 8;
  localparam int NS = W / SL;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          signedMode;
  logic [W-1:0]  busA;
  logic [W-1:0]  busB;
  logic          busy;
  logic          done;
  logic [1:0]    dataOut;
  logic          zeroFlag;
  logic          overflowFlag;
  logic          carryoutFlag;
  logic          negativeFlag;

  int tests = 0;
  int fails = 0;

  compare_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk), .reset(reset), .start(start), .signedMode(signedMode),
    .busA(busA), .busB(busB), .busy(busy), .done(done), .dataOut(dataOut),
    .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
    .carryoutFlag(carryoutFlag), .negativeFlag(negativeFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer compare in the dataOut encoding.
  function automatic logic [1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sm);
    if (sm) begin
      if ($signed(a) > $signed(b)) return 2'b01;
      else if ($signed(a) < $signed(b)) return 2'b10;
      else return 2'b00;
    end else begin
      if (a > b) return 2'b01;
      else if (a < b) return 2'b10;
      else return 2'b00;
    end
  endfunction

  // Reference latency: the slice count, or the distance to the highest
  // differing byte when early exit is built in.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARE_EARLY_EXIT_EN
    for (int s = NS - 1; s >= 0; s--) begin
      if (a[s*SL +: SL] != b[s*SL +: SL]) return NS - s;
    end
    return NS;
`else
    return NS;
`endif
  endfunction

  // The caller is at a negedge. Drive a request, let E0 sample it, scramble
  // the inputs, then wait (bounded) for done. Returns at the done negedge.
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        output int lat);
    start = 1'b1; busA = a; busB = b; signedMode = sm;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; busA = $urandom; busB = $urandom; signedMode = ~sm;
    check("busy_after_start", busy, 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check("done_timeout", 0, 1);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sm, input int lat);
    logic [1:0] er;
    er = ref_res(a, b, sm);
    check({name, "_data"}, dataOut, er);
    check({name, "_neg"},  negativeFlag, (er == 2'b10) ? 1 : 0);
    check({name, "_zero"}, zeroFlag, (a == 0 && b == 0) ? 1 : 0);
    check({name, "_ovf_cy"}, {overflowFlag, carryoutFlag}, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_lat"},  lat, ref_lat(a, b));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [1:0]   exp_res;
    logic         exp_zero;
    int           lat_full;
    int           lat_early;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    int ndone;
    vec_t v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 4, 4});
    vecs.push_back('{32'h1234_5678, 32'h1234_5679, 1'b0, 2'b10, 1'b0, 4, 4});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 2'b01, 1'b0, 4, 1});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 2'b10, 1'b0, 4, 1});
    vecs.push_back('{32'h0000_0007, 32'h0000_0007, 1'b1, 2'b00, 1'b0, 4, 4});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2'b10, 1'b0, 4, 1});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2'b01, 1'b0, 4, 1});
    vecs.push_back('{32'h0001_0000, 32'h0000_FFFF, 1'b0, 2'b01, 1'b0, 4, 2});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2'b01, 1'b0, 4, 1});
    vecs.push_back('{32'h0000_8000, 32'h0000_7F00, 1'b1, 2'b01, 1'b0, 4, 3});

    reset = 1'b1; start = 1'b0; signedMode = 1'b0; busA = '0; busB = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", dataOut, 0);
    check("rst_flags", {zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
      v = vecs[i];
      do_cmp(v.a, v.b, v.sm, lat);
      check($sformatf("vec%0d_data", i), dataOut, v.exp_res);
      check($sformatf("vec%0d_neg", i), negativeFlag, (v.exp_res == 2'b10) ? 1 : 0);
      check($sformatf("vec%0d_zero", i), zeroFlag, v.exp_zero);
      check($sformatf("vec%0d_busy", i), busy, 0);
`ifdef COMPARE_EARLY_EXIT_EN
      check($sformatf("vec%0d_lat", i), lat, v.lat_early);
`else
      check($sformatf("vec%0d_lat", i), lat, v.lat_full);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_hold", i), dataOut, v.exp_res);
    end

    // Start while busy: the second request at E0+2 must be ignored.
    start = 1'b1; busA = 32'd5; busB = 32'd3; signedMode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    @(negedge clk);
    if (done) ndone++;
    start = 1'b1; busA = 32'd0; busB = 32'd9;
    @(negedge clk);
    if (done) ndone++;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_data", dataOut, 2'b01);
    check("busy_start_zero", zeroFlag, 0);
    check("busy_start_idle", busy, 0);

    // Reset in the middle of a compare.
    start = 1'b1; busA = 32'hFFFF_FFFF; busB = 32'd0; signedMode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_data", dataOut, 0);
    check("midrst_flags", {zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    do_cmp(32'd7, 32'd7, 1'b0, lat);
    check_result("after_rst", 32'd7, 32'd7, 1'b0, lat);

    // Back-to-back: the next start lands in the done cycle.
    @(negedge clk);
    do_cmp(32'd2, 32'd1, 1'b0, lat);
    check_result("b2b_first", 32'd2, 32'd1, 1'b0, lat);
    do_cmp(32'd1, 32'd2, 1'b0, lat);
    check_result("b2b_second", 32'd1, 32'd2, 1'b0, lat);

    // Randomised compares against the reference model. Half of them share
    // the upper bytes, so the difference lands in a lower slice.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1, 0));
      if (n % 2 == 0) begin
        rb = ra ^ (W'($urandom_range(255, 0)) << (SL * $urandom_range(NS - 1, 0)));
      end
      if (n % 7 == 0) rb = ra;
      do_cmp(ra, rb, rs, lat);
      check_result($sformatf("rand%0d", n), ra, rb, rs, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/compare_seq.md
# compare_seq

Parametrised multi-cycle magnitude comparator for the lab3 datapath, generalising the single-cycle 32-bit compare. It compares `WIDTH`-bit operands one `SLICE`-bit slice per clock, most-significant slice first. It supports unsigned and two's-complement signed modes and uses a start/busy/done handshake. Results use the same two-bit `dataOut` encoding and four-flag set as the ALU compare path, so it can sit behind the ALU result mux.

## Interface
Parameters:
- `WIDTH`, 32, operand width; must be a nonzero multiple of `SLICE`.
- `SLICE`, 8, bits compared per cycle; `NSLICE = WIDTH/SLICE`.

Ports:
- `clk` input 1, single clock; all state updates on its rising edge.
- `reset` input 1, synchronous, active-high.
- `start` input 1, request; sampled only while idle (`busy` low).
- `signedMode` input 1, 1 = two's-complement compare, 0 = unsigned; captured with `start`.
- `busA` input `WIDTH`, operand A; captured with `start`.
- `busB` input `WIDTH`, operand B; captured with `start`.
- `busy` output 1, high while a compare is in progress.
- `done` output 1, one-cycle pulse when results update.
- `dataOut` output 2, compare result: 00 = A==B, 01 = A>B, 10 = A<B; 11 never produced.
- `zeroFlag` output 1, high when both captured operands are all-zero.
- `overflowFlag` output 1, constant 0.
- `carryoutFlag` output 1, constant 0.
- `negativeFlag` output 1, high exactly when `dataOut` == 10.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE, `start`=1:
  - Latch `busA`, `busB` and `signedMode`.
  - Register the pending zero result `zeroPend` = (`busA`==0 && `busB`==0).
  - Set slice index `idx` = `NSLICE`-1.
  - Go to RUN.
- RUN, each cycle:
  - Compare slice `idx` of A against slice `idx` of B as unsigned numbers.
  - When `signedMode`=1 and `idx`=`NSLICE`-1, invert the top bit of both slices before comparing. This is the sign-bias trick.
  - First differing slice decides the result: A-slice greater → 01, smaller → 10.
  - All slices equal → 00.
- Termination:
  - `idx`==0 ends the compare.
  - With early exit compiled in, the first differing slice also ends it.
  - On the terminating edge:
    - Drive `dataOut`, `negativeFlag`, and `zeroFlag` (from `zeroPend`).
    - Pulse `done`.
    - Return to IDLE.
  - Otherwise, `idx` decrements.
- Results and flags hold their values until the next termination or `reset`.
- `start` while `busy` is ignored; captured operands are unaffected.
- `start` in the `done` cycle is accepted, since `busy` is already low.
- Input changes after capture have no effect on the running compare.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`=0, `done`=0, `dataOut`=00.
  - `zeroFlag`=0, `overflowFlag`=0, `carryoutFlag`=0, `negativeFlag`=0.
- Timing is counted from edge E0, the edge on which `start` is sampled.
- `busy` is high from the cycle after E0.
- Full latency: the last slice is processed on edge E(`NSLICE`). `done`, the new results and `busy`=0 are all visible in the cycle after E(`NSLICE`). That is `NSLICE` cycles after E0; 4 cycles at the defaults.
- Early-exit latency: when the first difference is in slice i, `done` follows edge E(`NSLICE`-i).
- Back-to-back compares:
  - Minimum period `NSLICE`+1 cycles with no early exit.
  - `done` and the next accepted `start` can share a cycle.
- `reset` in any cycle, including mid-RUN or during `done`, returns to the reset values on that edge with no `done` pulse. The partial compare is discarded.

## Configuration
- `COMPARE_EARLY_EXIT_EN` defined:
  - RUN terminates on the first differing slice.
  - Latency is 1..`NSLICE` cycles, depending on the data.
- `COMPARE_EARLY_EXIT_EN` undefined:
  - Every compare runs all `NSLICE` slices.
  - Latency is constant at `NSLICE` cycles.
  - The first difference is held; later slices do not override it.
- Results are identical in both builds; only latency differs.

## Test plan
All scenarios use the defaults (`WIDTH`=32, `SLICE`=8).
- Zero operands: A=0, B=0, unsigned.
  - `dataOut`=00, `zeroFlag`=1, `negativeFlag`=0.
  - `done` 4 cycles after E0 in both builds.
- Difference in the lowest slice: A=0x12345678, B=0x12345679, unsigned.
  - `dataOut`=10, `negativeFlag`=1, `zeroFlag`=0.
  - Latency 4 in both builds.
- Signed vs unsigned: A=0x80000000, B=0x00000001.
  - Unsigned → `dataOut`=01, `negativeFlag`=0.
  - Signed → `dataOut`=10, `negativeFlag`=1.
  - Latency 1 with `COMPARE_EARLY_EXIT_EN`, 4 without.
- Start while busy: start A=5, B=3; pulse `start` again with A=0, B=9 at E0+2.
  - Second request ignored.
  - Result 01, `zeroFlag`=0, exactly one `done`.
- Reset mid-compare: start A=0xFFFFFFFF, B=0, assert `reset` at E0+2.
  - Next cycle: `busy`=0, `dataOut`=00, all flags 0, no `done`.
  - A following compare of A=B=7 returns 00 with `zeroFlag`=0.
- Back-to-back: assert `start` (A=1, B=2) in the `done` cycle of a prior compare (A=2, B=1).
  - Results 01 then 10.
  - Second `done` 4 cycles after its start in the no-early-exit build.
